// File: rtl/instr_fetch_queue.sv
// Fetch front end: credit-limited imem requests, an in-order tag queue and a small instruction FIFO.
// Optional macro IFQ_BYPASS_EN forwards a response straight to decode when the FIFO is empty.
module instr_fetch_queue #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] instr_pc_plus4
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned SW = AW + 2;
   localparam int unsigned DW = 16;
   localparam logic [SW-1:0] DEPTH_L = SW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   fifo_data_q [DEPTH];
   logic [31:0]   fifo_pc_q   [DEPTH];
   logic [31:0]   tag_pc_q    [DEPTH];
   logic [AW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
   logic [AW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
   logic [CW-1:0] fifo_cnt_q, fifo_cnt_d, outst_q, outst_d;
   logic [DW-1:0] drop_q, drop_d;

   logic [SW-1:0] credit_sum_s;
   logic          credit_ok_s, hs_s, resp_any_s, resp_live_s, resp_drop_s;
   logic          fifo_nonempty_s, fifo_push_s, fifo_pop_s, bypass_s;
   logic          unused_ok_s;

   assign unused_ok_s     = &{1'b0, redirect_pc[1:0]};
   assign credit_sum_s    = SW'(fifo_cnt_q) + SW'(outst_q);
   assign credit_ok_s     = credit_sum_s < DEPTH_L;
   assign imem_req_valid  = credit_ok_s && !redirect_valid && rst;
   assign imem_req_addr   = fetch_pc_q;
   assign hs_s            = imem_req_valid && imem_req_ready;
   assign resp_any_s      = imem_resp_valid && ((drop_q != DW'(0)) || (outst_q != CW'(0)));
   assign resp_drop_s     = imem_resp_valid && (drop_q != DW'(0));
   // Live responses belong to the current path; stray beats with no credit are ignored.
   assign resp_live_s     = imem_resp_valid && (drop_q == DW'(0)) && (outst_q != CW'(0));
   assign fifo_nonempty_s = fifo_cnt_q != CW'(0);

`ifdef IFQ_BYPASS_EN
   assign bypass_s = !fifo_nonempty_s && !stall && !redirect_valid && resp_live_s;
`else
   assign bypass_s = 1'b0;
`endif

   assign fifo_push_s = resp_live_s && !bypass_s && !redirect_valid;
   assign fifo_pop_s  = fifo_nonempty_s && !stall && !redirect_valid;

   // Head presentation to decode.
   always_comb begin
      instr_valid = 1'b0;
      instr       = NOP_INSTR;
      instr_pc    = 32'h0000_0000;
      if (bypass_s) begin
         instr_valid = 1'b1;
         instr       = imem_resp_data;
         instr_pc    = tag_pc_q[tag_rd_q];
      end else if (fifo_nonempty_s) begin
         instr_valid = 1'b1;
         instr       = fifo_data_q[fifo_rd_q];
         instr_pc    = fifo_pc_q[fifo_rd_q];
      end else begin
         instr_valid = 1'b0;
         instr       = NOP_INSTR;
         instr_pc    = 32'h0000_0000;
      end
   end

   assign instr_pc_plus4 = instr_pc + 32'd4;

   // Next-state: a redirect turns every in-flight request into a drop and restarts at the target.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      fifo_rd_d  = fifo_rd_q;
      fifo_wr_d  = fifo_wr_q;
      fifo_cnt_d = fifo_cnt_q;
      tag_rd_d   = tag_rd_q;
      tag_wr_d   = tag_wr_q;
      outst_d    = outst_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         fifo_rd_d  = AW'(0);
         fifo_wr_d  = AW'(0);
         fifo_cnt_d = CW'(0);
         tag_rd_d   = AW'(0);
         tag_wr_d   = AW'(0);
         outst_d    = CW'(0);
         drop_d     = drop_q + DW'(outst_q) - DW'(resp_any_s);
      end else begin
         fetch_pc_d = hs_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
         tag_wr_d   = hs_s ? tag_wr_q + AW'(1) : tag_wr_q;
         tag_rd_d   = resp_live_s ? tag_rd_q + AW'(1) : tag_rd_q;
         outst_d    = outst_q + CW'(hs_s) - CW'(resp_live_s);
         drop_d     = resp_drop_s ? drop_q - DW'(1) : drop_q;
         fifo_wr_d  = fifo_push_s ? fifo_wr_q + AW'(1) : fifo_wr_q;
         fifo_rd_d  = fifo_pop_s ? fifo_rd_q + AW'(1) : fifo_rd_q;
         fifo_cnt_d = fifo_cnt_q + CW'(fifo_push_s) - CW'(fifo_pop_s);
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q <= RESET_PC;
         fifo_rd_q  <= AW'(0);
         fifo_wr_q  <= AW'(0);
         fifo_cnt_q <= CW'(0);
         tag_rd_q   <= AW'(0);
         tag_wr_q   <= AW'(0);
         outst_q    <= CW'(0);
         drop_q     <= DW'(0);
      end else begin
         fetch_pc_q <= fetch_pc_d;
         fifo_rd_q  <= fifo_rd_d;
         fifo_wr_q  <= fifo_wr_d;
         fifo_cnt_q <= fifo_cnt_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
      end
   end

   // Storage arrays; contents are qualified by the pointers, so no reset is needed.
   always_ff @(posedge clk) begin
      if (hs_s) begin
         tag_pc_q[tag_wr_q] <= fetch_pc_q;
      end
      if (fifo_push_s) begin
         fifo_data_q[fifo_wr_q] <= imem_resp_data;
         fifo_pc_q[fifo_wr_q]   <= tag_pc_q[tag_rd_q];
      end
   end

`ifndef SYNTHESIS
   instr_fetch_queue_chk u_chk (
      .clk        (clk),
      .rst        (rst),
      .resp_valid (imem_resp_valid),
      .idle       ((drop_q == DW'(0)) && (outst_q == CW'(0)))
   );
`endif
endmodule

// Protocol checker: a response beat must always correspond to an issued request.
module instr_fetch_queue_chk (
   input logic clk,
   input logic rst,
   input logic resp_valid,
   input logic idle
);
   a_resp_has_credit : assert property (@(posedge clk) disable iff (!rst) !(resp_valid && idle));
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a queue-based reference model and a latency-programmable memory.
module tb_instr_fetch_queue;
   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'd0;
   logic        instr_valid;
   logic [31:0] instr, instr_pc, instr_pc_plus4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] exp_pc;
      int          due;
      bit          live;
   } mem_t;

   mem_t        mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] m_fetch = 32'h0000_0000;

   instr_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr_valid(instr_valid), .instr(instr),
      .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'h5A5A_F00D;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory: presents the oldest due response shortly after each rising edge.
   always @(posedge clk) begin
      #1;
      cyc = cyc + 1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mdata(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'd0;
      end
   end

   // Reference model: compare every cycle, then apply the events of the coming edge.
   always @(negedge clk) begin
      int   live;
      bit   exp_rv, resp_live;
      mem_t front;
      live = 0;
      foreach (mq[i]) if (mq[i].live) live++;
      chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("instr_pc", instr_pc, exp_q[0]);
         chk("instr", instr, mdata(exp_q[0]));
         chk("instr_pc_plus4", instr_pc_plus4, exp_q[0] + 32'd4);
      end else begin
         chk("instr_nop", instr, NOP);
      end
      exp_rv = (rst === 1'b1) && (redirect_valid !== 1'b1) && (exp_q.size() + live < DEPTH);
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      if (imem_req_valid === 1'b1) chk("req_addr", imem_req_addr, m_fetch);

      if (rst !== 1'b1) begin
         exp_q.delete();
         mq.delete();
         m_fetch = 32'h0000_0000;
      end else begin
         resp_live = 1'b0;
         if (imem_resp_valid === 1'b1 && mq.size() > 0) begin
            front     = mq.pop_front();
            resp_live = front.live;
         end
         if (redirect_valid === 1'b1) begin
            exp_q.delete();
            for (int i = 0; i < mq.size(); i++) mq[i].live = 1'b0;
            m_fetch = {redirect_pc[31:2], 2'b00};
         end else begin
            if (exp_q.size() > 0 && stall !== 1'b1) void'(exp_q.pop_front());
            if (resp_live) exp_q.push_back(front.exp_pc);
            if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
               mq.push_back('{addr: imem_req_addr, exp_pc: m_fetch, due: cyc + lat, live: 1'b1});
               m_fetch = m_fetch + 32'd4;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_instr(input int max_cyc);
      int n;
      n = 0;
      @(negedge clk);
      while (instr_valid !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_instr", 32'(instr_valid), 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; imem_req_ready = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'h0000_0013);
      chk("rst_pc", instr_pc, 32'h0000_0000);
      chk("rst_pc4", instr_pc_plus4, 32'h0000_0004);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);

      // Basic streaming, latency 1.
      tick(); rst = 1'b1;
      @(negedge clk);
      chk("first_req_valid", 32'(imem_req_valid), 32'd1);
      chk("first_req_addr", imem_req_addr, 32'h0000_0000);
      wait_instr(10);
      chk("first_pc", instr_pc, 32'h0000_0000);
      chk("first_pc4", instr_pc_plus4, 32'h0000_0004);
      chk("first_instr", instr, 32'h5A5A_F00D);
      @(negedge clk); chk("stream_pc4", instr_pc, 32'h0000_0004);
      @(negedge clk); chk("stream_pc8", instr_pc, 32'h0000_0008);

      // Stall from reset release: credit exhausts, then drain in order.
      tick(); rst = 1'b0; stall = 1'b1;
      tick(); rst = 1'b1;
      repeat (5) tick();
      @(negedge clk);
      chk("stall_full_req", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", instr_pc, 32'h0000_0000);
      tick(); stall = 1'b0;
      @(negedge clk); chk("drain0", instr_pc, 32'h0000_0000);
      @(negedge clk); chk("drain4", instr_pc, 32'h0000_0004);
      @(negedge clk); chk("drain8", instr_pc, 32'h0000_0008);
      @(negedge clk); chk("drainC", instr_pc, 32'h0000_000C);

      // Latency 3, two outstanding, redirect drops both.
      tick(); rst = 1'b0; lat = 3;
      tick(); rst = 1'b1;
      tick();
      tick(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
      tick(); imem_req_ready = 1'b1; redirect_valid = 1'b0;
      @(negedge clk);
      chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
      chk("redir_no_valid", 32'(instr_valid), 32'd0);
      wait_instr(20);
      chk("redir_first_pc", instr_pc, 32'h0000_0100);
      chk("redir_first_instr", instr, 32'h5A5A_F10D);

      // Unaligned redirect target.
      tick(); lat = 1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
      tick(); redirect_valid = 1'b0;
      @(negedge clk); chk("align_addr", imem_req_addr, 32'h0000_0200);

      // Redirect together with stall on a full FIFO.
      tick(); stall = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      chk("full_req_valid", 32'(imem_req_valid), 32'd0);
      chk("full_valid", 32'(instr_valid), 32'd1);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
      tick(); redirect_valid = 1'b0; stall = 1'b0;
      @(negedge clk);
      chk("rs_valid", 32'(instr_valid), 32'd0);
      chk("rs_req_addr", imem_req_addr, 32'h0000_0400);

      // Address wrap at 2^32.
      tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      tick(); redirect_valid = 1'b0;
      @(negedge clk); chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk); chk("wrap_addr1", imem_req_addr, 32'h0000_0000);
      wait_instr(10);
      chk("wrap_pc", instr_pc, 32'hFFFF_FFFC);
      chk("wrap_pc4", instr_pc_plus4, 32'h0000_0000);
      @(negedge clk); chk("wrap_next_pc", instr_pc, 32'h0000_0000);

      // Reset with three requests in flight.
      tick(); lat = 4; redirect_valid = 1'b1; redirect_pc = 32'h0000_0800;
      tick(); redirect_valid = 1'b0;
      tick();
      tick();
      tick(); rst = 1'b0;
      tick(); rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_valid", 32'(instr_valid), 32'd0);
      chk("mid_rst_instr", instr, 32'h0000_0013);
      chk("mid_rst_pc", instr_pc, 32'h0000_0000);
      chk("mid_rst_pc4", instr_pc_plus4, 32'h0000_0004);
      chk("mid_rst_addr", imem_req_addr, 32'h0000_0000);
      wait_instr(20);
      chk("mid_rst_first_pc", instr_pc, 32'h0000_0000);

      // Mixed stall pattern with a redirect mid-stream, latency 2.
      lat = 2;
      for (int i = 0; i < 40; i++) begin
         tick();
         stall          = (i % 3 == 1);
         redirect_valid = (i == 20);
         redirect_pc    = 32'h0000_0040;
      end
      tick(); stall = 1'b0; redirect_valid = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch-stage front end that feeds the pipeline's fetch/decode register.
- Issues word-aligned requests to a variable-latency instruction memory using a valid/ready request channel and an in-order response channel.
- Buffers returned instructions with their PC and PC+4 in a small FIFO, and presents them to decode.
- Honours decode stall and execute-stage redirects (taken branch, jal, jalr), discarding all wrong-path work.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests combined; power of two, 2..16.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr when instr_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset asserted), sampled on rising clk.
- stall  in  1  decode cannot accept (StallD); holds the head entry.
- redirect_valid  in  1  execute-stage control transfer (PCSrcE != 0).
- redirect_pc  in  32  target address; bits [1:0] ignored and treated as 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned byte address.
- imem_resp_valid  in  1  response beat; in order, one per accepted request, any latency >= 1 cycle.
- imem_resp_data  in  32  instruction word.
- instr_valid  out  1  head entry valid.
- instr  out  32  head instruction (NOP_INSTR when invalid).
- instr_pc  out  32  PC of head instruction.
- instr_pc_plus4  out  32  instr_pc + 4, modulo 2^32.

Behaviour:
- Reset (rst=0 at an edge):
  - fetch_pc <= RESET_PC; FIFO emptied; outstanding count = 0; drop count = 0.
  - Outputs: instr_valid=0, instr=NOP_INSTR, instr_pc=0, instr_pc_plus4=4, imem_req_valid=0.
  - Reset asserted mid-operation abandons all in-flight requests. Responses arriving after reset release are NOT dropped, so the memory must also be reset by the same rst.
- Request credit:
  - imem_req_valid = (fifo_count + outstanding < DEPTH) && !redirect_valid && reset released.
  - imem_req_addr = fetch_pc.
  - On handshake (valid && ready): fetch_pc <= fetch_pc + 4 (wraps at 2^32); outstanding += 1; the request PC is pushed into an internal DEPTH-entry tag queue.
- Responses:
  - A response with drop count > 0 decrements the drop count and pops its tag only; it is not written to the FIFO.
  - Otherwise the response is pushed to the FIFO as {data, tag PC, tag PC+4}, and outstanding -= 1.
  - The credit rule guarantees the FIFO never overflows. A response arriving with outstanding=0 and drop count=0 is a protocol error: ignore it; an assertion fires in simulation.
- Dequeue:
  - The head pops when instr_valid && !stall.
  - Push and pop may occur in the same cycle; the count is unchanged.
  - While stall=1, all head outputs hold stable.
- Latency: a response is visible on instr_valid on the next cycle (registered FIFO output). Back-to-back single-cycle memory sustains one instruction per cycle.
- Redirect (redirect_valid=1 at an edge) takes priority over pop, push and request in that cycle:
  - FIFO flushed.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Drop count <= outstanding + (1 if a request handshake would have completed this cycle) - (1 if a response arrived this cycle). With imem_req_valid=0 during redirect, the handshake term is 0.
  - outstanding <= 0; the tag queue retains only the drop entries.
  - The next cycle requests the target. instr_valid=0 until the target response arrives.
- Simultaneous redirect and stall: redirect wins.
- Consecutive redirects: drop counts accumulate correctly.
- Full: fifo_count + outstanding == DEPTH forces imem_req_valid=0 until a pop.
- Empty: instr_valid=0 and instr=NOP_INSTR.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When the FIFO is empty, stall=0, redirect_valid=0, and a non-dropped response arrives, the response is driven combinationally on instr/instr_pc/instr_pc_plus4 with instr_valid=1 in the same cycle, and is consumed without entering the FIFO.
  - Credit accounting is unchanged.
- Not defined: responses always pass through the FIFO, giving 1-cycle latency from response to instr_valid.

Test Plan:
- Reset release, memory ready=1, latency 1 -> first request addr 0x0; instr_valid rises with instr_pc=0x0, then 0x4, 0x8 on consecutive cycles; instr_pc_plus4=0x4.
- Hold stall=1 for 6 cycles with DEPTH=4 -> at most 4 accepted requests; imem_req_valid=0 after credit is exhausted; head outputs unchanged; after release, PCs 0x0..0xC drain in order with none lost.
- Memory latency 3 with 2 outstanding, then redirect_pc=0x100 -> both late responses dropped (never appear on instr); next request addr 0x100; first valid instr_pc=0x100.
- Redirect with redirect_pc=0x203 -> imem_req_addr=0x200.
- Redirect and stall asserted in the same cycle with a full FIFO -> FIFO emptied, instr_valid=0 next cycle, fetch from target.
- fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000; instr_pc_plus4 for that entry = 0x0.
- rst=0 for 1 cycle while 3 requests are outstanding -> all outputs at reset values next cycle; fetch restarts at RESET_PC.
